// File: rtl/mips_pipe_pkg.sv
// Shared pipeline-control types for the MIPS hazard/forwarding scoreboard:
// forward-select codes, the shadow stage-entry struct and its bubble value.
package mips_pipe_pkg;

  // Shadow entries carry up to this many destination bits; REG_AW must not exceed it.
  localparam int DEST_W = 8;

  localparam logic [1:0] FWD_REG = 2'd0;
  localparam logic [1:0] FWD_MEM = 2'd1;
  localparam logic [1:0] FWD_WB  = 2'd2;

  typedef struct packed {
    logic              valid;
    logic [DEST_W-1:0] dest;
    logic              wb_en;
    logic              mem_r;
  } stage_ctl_t;

  localparam stage_ctl_t STAGE_BUBBLE = '{
    valid: 1'b0,
    dest:  {DEST_W{1'b0}},
    wb_en: 1'b0,
    mem_r: 1'b0
  };

  // The nearer stage holds the younger value, so MEM beats WB.
  function automatic logic [1:0] pick_fwd(input logic mem_hit, input logic wb_hit);
    logic [1:0] sel;
    if (mem_hit) begin
      sel = FWD_MEM;
    end else if (wb_hit) begin
      sel = FWD_WB;
    end else begin
      sel = FWD_REG;
    end
    return sel;
  endfunction

endpackage

// File: rtl/hazard_fwd_scoreboard_reg_match.sv
// Combinational producer/consumer comparator: a stage entry that will write a
// nonzero register equal to a source the consumer actually reads.
module reg_match #(
  parameter int REG_AW = 5
) (
  input  logic              valid,
  input  logic              wb_en,
  input  logic [REG_AW-1:0] dest,
  input  logic [REG_AW-1:0] src,
  input  logic              src_used,
  output logic              match
);

  // Register 0 is hardwired zero, so it never creates a dependency.
  always_comb begin
    match = valid & wb_en & src_used & (dest != {REG_AW{1'b0}}) & (dest == src);
  end

endmodule

// File: rtl/hazard_fwd_scoreboard.sv
// Hazard and forwarding controller for the 5-stage pipeline with shadow EX/MEM/WB
// control state and a multi-cycle load wait that freezes the whole pipeline.
module hazard_fwd_scoreboard
  import mips_pipe_pkg::*;
#(
  parameter int REG_AW   = 5,
  parameter int MEM_WAIT = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              is_forward,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_src1,
  input  logic [REG_AW-1:0] id_src2,
  input  logic              id_src2_used,
  input  logic [REG_AW-1:0] id_dest,
  input  logic              id_wb_en,
  input  logic              id_mem_r_en,
  input  logic              flush,
  output logic              hazard,
  output logic              freeze,
  output logic              mem_busy,
  output logic [1:0]        fwd_a_sel,
  output logic [1:0]        fwd_b_sel
);

  stage_ctl_t        ex_r;
  stage_ctl_t        mem_stage_r;
  stage_ctl_t        wb_r;
  logic [REG_AW-1:0] ex_src1_r;
  logic [REG_AW-1:0] ex_src2_r;
  logic              ex_src2_used_r;

  stage_ctl_t        id_ent_s;
  logic              mem_busy_s;
  logic              flush_eff_s;
  logic              hazard_s;
  logic              ex_m1_s, ex_m2_s, mem_m1_s, mem_m2_s;
  logic              fa_mem_s, fb_mem_s, fa_wb_s, fb_wb_s;
  logic [1:0]        fwd_a_s, fwd_b_s;
  logic              unused_s;

  assign id_ent_s = '{
    valid: 1'b1,
    dest:  DEST_W'(id_dest),
    wb_en: id_wb_en,
    mem_r: id_mem_r_en
  };

  // A branch cannot be taken while the pipeline is frozen, so flush only counts when advancing.
  assign flush_eff_s = flush & ~mem_busy_s;

  // ID sources against the EX and MEM producers (hazard detection).
  reg_match #(.REG_AW(REG_AW)) u_ex_src1 (
    .valid(ex_r.valid), .wb_en(ex_r.wb_en), .dest(ex_r.dest[REG_AW-1:0]),
    .src(id_src1), .src_used(1'b1), .match(ex_m1_s));
  reg_match #(.REG_AW(REG_AW)) u_ex_src2 (
    .valid(ex_r.valid), .wb_en(ex_r.wb_en), .dest(ex_r.dest[REG_AW-1:0]),
    .src(id_src2), .src_used(id_src2_used), .match(ex_m2_s));
  reg_match #(.REG_AW(REG_AW)) u_mem_src1 (
    .valid(mem_stage_r.valid), .wb_en(mem_stage_r.wb_en), .dest(mem_stage_r.dest[REG_AW-1:0]),
    .src(id_src1), .src_used(1'b1), .match(mem_m1_s));
  reg_match #(.REG_AW(REG_AW)) u_mem_src2 (
    .valid(mem_stage_r.valid), .wb_en(mem_stage_r.wb_en), .dest(mem_stage_r.dest[REG_AW-1:0]),
    .src(id_src2), .src_used(id_src2_used), .match(mem_m2_s));

  // EX sources against the MEM and WB producers (forward selection).
  reg_match #(.REG_AW(REG_AW)) u_fwd_mem_a (
    .valid(mem_stage_r.valid), .wb_en(mem_stage_r.wb_en), .dest(mem_stage_r.dest[REG_AW-1:0]),
    .src(ex_src1_r), .src_used(1'b1), .match(fa_mem_s));
  reg_match #(.REG_AW(REG_AW)) u_fwd_mem_b (
    .valid(mem_stage_r.valid), .wb_en(mem_stage_r.wb_en), .dest(mem_stage_r.dest[REG_AW-1:0]),
    .src(ex_src2_r), .src_used(ex_src2_used_r), .match(fb_mem_s));
  reg_match #(.REG_AW(REG_AW)) u_fwd_wb_a (
    .valid(wb_r.valid), .wb_en(wb_r.wb_en), .dest(wb_r.dest[REG_AW-1:0]),
    .src(ex_src1_r), .src_used(1'b1), .match(fa_wb_s));
  reg_match #(.REG_AW(REG_AW)) u_fwd_wb_b (
    .valid(wb_r.valid), .wb_en(wb_r.wb_en), .dest(wb_r.dest[REG_AW-1:0]),
    .src(ex_src2_r), .src_used(ex_src2_used_r), .match(fb_wb_s));

  // Stall decision; WB producers never stall because the regfile writes before it reads.
  always_comb begin
    hazard_s = 1'b0;
    if (!id_valid || flush_eff_s) begin
      hazard_s = 1'b0;
    end else if (is_forward) begin
      hazard_s = ex_r.mem_r & (ex_m1_s | ex_m2_s);
    end else begin
      hazard_s = ex_m1_s | ex_m2_s | mem_m1_s | mem_m2_s;
    end
  end

  // Operand selects for EX; load data is not available in MEM, so a load there never forwards.
  always_comb begin
    fwd_a_s = FWD_REG;
    fwd_b_s = FWD_REG;
    if (!ex_r.valid || !is_forward) begin
      fwd_a_s = FWD_REG;
      fwd_b_s = FWD_REG;
    end else begin
      fwd_a_s = pick_fwd(fa_mem_s & ~mem_stage_r.mem_r, fa_wb_s);
      fwd_b_s = pick_fwd(fb_mem_s & ~mem_stage_r.mem_r, fb_wb_s);
    end
  end

  generate
    if (MEM_WAIT > 0) begin : g_wait
      localparam int CNT_W = $clog2(MEM_WAIT + 1);
      logic [CNT_W-1:0] cnt_r;

      // Wait counter: armed when a valid load advances into MEM, counts down while busy.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          cnt_r <= {CNT_W{1'b0}};
        end else if (cnt_r != {CNT_W{1'b0}}) begin
          cnt_r <= cnt_r - CNT_W'(1);
        end else if (ex_r.valid && ex_r.mem_r) begin
          cnt_r <= CNT_W'(MEM_WAIT);
        end else begin
          cnt_r <= {CNT_W{1'b0}};
        end
      end

      assign mem_busy_s = (cnt_r != {CNT_W{1'b0}});
    end else begin : g_no_wait
      assign mem_busy_s = 1'b0;
    end
  endgenerate

  // Shadow pipeline: shifts on advancing cycles, holds completely while a load waits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_r           <= STAGE_BUBBLE;
      mem_stage_r    <= STAGE_BUBBLE;
      wb_r           <= STAGE_BUBBLE;
      ex_src1_r      <= {REG_AW{1'b0}};
      ex_src2_r      <= {REG_AW{1'b0}};
      ex_src2_used_r <= 1'b0;
    end else if (!mem_busy_s) begin
      wb_r        <= mem_stage_r;
      mem_stage_r <= ex_r;
      if (id_valid && !hazard_s && !flush) begin
        ex_r           <= id_ent_s;
        ex_src1_r      <= id_src1;
        ex_src2_r      <= id_src2;
        ex_src2_used_r <= id_src2_used;
      end else begin
        ex_r           <= STAGE_BUBBLE;
        ex_src1_r      <= {REG_AW{1'b0}};
        ex_src2_r      <= {REG_AW{1'b0}};
        ex_src2_used_r <= 1'b0;
      end
    end
  end

  assign hazard    = hazard_s;
  assign freeze    = hazard_s | mem_busy_s;
  assign mem_busy  = mem_busy_s;
  assign fwd_a_sel = fwd_a_s;
  assign fwd_b_sel = fwd_b_s;

  assign unused_s = ^{wb_r, mem_stage_r.dest, ex_r.dest};

endmodule

// File: tb/tb_hazard_fwd_scoreboard.sv
// Bench for hazard_fwd_scoreboard: directed pipeline scenarios plus randomized
// traffic checked against an instruction-level pipeline model.
module tb_hazard_fwd_scoreboard;

  logic clk = 1'b0;
  logic rst;
  logic [1:0]      is_forward, id_valid, id_src2_used, id_wb_en, id_mem_r_en, flush;
  logic [1:0][4:0] id_src1, id_src2, id_dest;
  logic [1:0]      hazard, freeze, mem_busy;
  logic [1:0][1:0] fwd_a_sel, fwd_b_sel;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hazard_fwd_scoreboard #(.REG_AW(5), .MEM_WAIT(0)) dut0 (
    .clk(clk), .rst(rst), .is_forward(is_forward[0]), .id_valid(id_valid[0]),
    .id_src1(id_src1[0]), .id_src2(id_src2[0]), .id_src2_used(id_src2_used[0]),
    .id_dest(id_dest[0]), .id_wb_en(id_wb_en[0]), .id_mem_r_en(id_mem_r_en[0]),
    .flush(flush[0]), .hazard(hazard[0]), .freeze(freeze[0]), .mem_busy(mem_busy[0]),
    .fwd_a_sel(fwd_a_sel[0]), .fwd_b_sel(fwd_b_sel[0]));

  hazard_fwd_scoreboard #(.REG_AW(5), .MEM_WAIT(3)) dut1 (
    .clk(clk), .rst(rst), .is_forward(is_forward[1]), .id_valid(id_valid[1]),
    .id_src1(id_src1[1]), .id_src2(id_src2[1]), .id_src2_used(id_src2_used[1]),
    .id_dest(id_dest[1]), .id_wb_en(id_wb_en[1]), .id_mem_r_en(id_mem_r_en[1]),
    .flush(flush[1]), .hazard(hazard[1]), .freeze(freeze[1]), .mem_busy(mem_busy[1]),
    .fwd_a_sel(fwd_a_sel[1]), .fwd_b_sel(fwd_b_sel[1]));

  // Instruction-level model: what sits in EX, MEM and WB, plus remaining load wait.
  typedef struct {
    bit       v;
    bit [4:0] d;
    bit       wb;
    bit       mr;
    bit [4:0] s1;
    bit [4:0] s2;
    bit       u;
  } instr_t;

  instr_t m_pipe [3];
  int     m_wait_left;

  function automatic bit writes(instr_t i, bit [4:0] r, bit used);
    return used && i.v && i.wb && (i.d != 5'd0) && (i.d == r);
  endfunction

  function automatic bit [1:0] model_sel(int k, bit [4:0] src, bit used);
    if (!m_pipe[0].v || !is_forward[k]) return 2'd0;
    if (writes(m_pipe[1], src, used) && !m_pipe[1].mr) return 2'd1;
    if (writes(m_pipe[2], src, used)) return 2'd2;
    return 2'd0;
  endfunction

  function automatic bit model_hazard(int k);
    bit busy;
    busy = (m_wait_left != 0);
    if (!id_valid[k] || (flush[k] && !busy)) return 1'b0;
    if (is_forward[k])
      return m_pipe[0].mr && (writes(m_pipe[0], id_src1[k], 1'b1) ||
                              writes(m_pipe[0], id_src2[k], id_src2_used[k]));
    return writes(m_pipe[0], id_src1[k], 1'b1) || writes(m_pipe[0], id_src2[k], id_src2_used[k]) ||
           writes(m_pipe[1], id_src1[k], 1'b1) || writes(m_pipe[1], id_src2[k], id_src2_used[k]);
  endfunction

  task automatic set_id(input int k, input logic v, input logic [4:0] s1, input logic [4:0] s2,
                        input logic u, input logic [4:0] d, input logic wb, input logic mr);
    id_valid[k] = v; id_src1[k] = s1; id_src2[k] = s2; id_src2_used[k] = u;
    id_dest[k] = d; id_wb_en[k] = wb; id_mem_r_en[k] = mr;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drain();
    for (int k = 0; k < 2; k++) begin
      set_id(k, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
      flush[k] = 1'b0;
    end
    repeat (12) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #2;
    for (int k = 0; k < 2; k++) begin
      checks++; if (hazard[k] !== 1'b0) begin errors++; $display("FAIL reset_hazard[%0d]: got %0d want 0", k, hazard[k]); end
      checks++; if (freeze[k] !== 1'b0) begin errors++; $display("FAIL reset_freeze[%0d]: got %0d want 0", k, freeze[k]); end
      checks++; if (mem_busy[k] !== 1'b0) begin errors++; $display("FAIL reset_busy[%0d]: got %0d want 0", k, mem_busy[k]); end
      checks++; if (fwd_a_sel[k] !== 2'd0) begin errors++; $display("FAIL reset_fwd_a[%0d]: got %0d want 0", k, fwd_a_sel[k]); end
      checks++; if (fwd_b_sel[k] !== 2'd0) begin errors++; $display("FAIL reset_fwd_b[%0d]: got %0d want 0", k, fwd_b_sel[k]); end
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_forward();
    is_forward[0] = 1'b1;
    set_id(0, 1'b1, 5'd1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0);   // add r3,r1,r2
    tick();
    set_id(0, 1'b1, 5'd3, 5'd3, 1'b1, 5'd4, 1'b1, 1'b0);   // sub r4,r3,r3
    #1;
    checks++; if (hazard[0] !== 1'b0) begin errors++; $display("FAIL b2b_id_hazard: got %0d want 0", hazard[0]); end
    tick();
    set_id(0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    #1;
    checks++; if (fwd_a_sel[0] !== 2'd1) begin errors++; $display("FAIL b2b_fwd_a: got %0d want 1", fwd_a_sel[0]); end
    checks++; if (fwd_b_sel[0] !== 2'd1) begin errors++; $display("FAIL b2b_fwd_b: got %0d want 1", fwd_b_sel[0]); end
    drain();
    set_id(0, 1'b1, 5'd1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0);   // add r3
    tick();
    set_id(0, 1'b1, 5'd1, 5'd2, 1'b1, 5'd7, 1'b1, 1'b0);   // independent add r7
    tick();
    set_id(0, 1'b1, 5'd3, 5'd3, 1'b1, 5'd4, 1'b1, 1'b0);   // sub r4,r3,r3
    tick();
    set_id(0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    #1;
    checks++; if (fwd_a_sel[0] !== 2'd2) begin errors++; $display("FAIL dist2_fwd_a: got %0d want 2", fwd_a_sel[0]); end
    checks++; if (fwd_b_sel[0] !== 2'd2) begin errors++; $display("FAIL dist2_fwd_b: got %0d want 2", fwd_b_sel[0]); end
    drain();
  endtask

  task automatic test_load_use();
    is_forward[0] = 1'b1;
    set_id(0, 1'b1, 5'd1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1);   // lw r5
    tick();
    set_id(0, 1'b1, 5'd5, 5'd0, 1'b1, 5'd6, 1'b1, 1'b0);   // add r6,r5,r0
    #1;
    checks++; if (hazard[0] !== 1'b1) begin errors++; $display("FAIL lu_fwd_hazard1: got %0d want 1", hazard[0]); end
    checks++; if (freeze[0] !== 1'b1) begin errors++; $display("FAIL lu_fwd_freeze1: got %0d want 1", freeze[0]); end
    tick();
    #1;
    checks++; if (hazard[0] !== 1'b0) begin errors++; $display("FAIL lu_fwd_hazard2: got %0d want 0", hazard[0]); end
    tick();
    set_id(0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    #1;
    checks++; if (fwd_a_sel[0] !== 2'd2) begin errors++; $display("FAIL lu_fwd_a: got %0d want 2", fwd_a_sel[0]); end
    checks++; if (fwd_b_sel[0] !== 2'd0) begin errors++; $display("FAIL lu_fwd_b: got %0d want 0", fwd_b_sel[0]); end
    drain();
    is_forward[0] = 1'b0;
    set_id(0, 1'b1, 5'd1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1);
    tick();
    set_id(0, 1'b1, 5'd5, 5'd0, 1'b1, 5'd6, 1'b1, 1'b0);
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if (hazard[0] !== (c < 2)) begin errors++; $display("FAIL lu_stall_hazard c%0d: got %0d want %0d", c, hazard[0], (c < 2)); end
      tick();
    end
    set_id(0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    #1;
    checks++; if (fwd_a_sel[0] !== 2'd0) begin errors++; $display("FAIL lu_stall_fwd_a: got %0d want 0", fwd_a_sel[0]); end
    drain();
  endtask

  task automatic test_reg_zero();
    is_forward[0] = 1'b1;
    set_id(0, 1'b1, 5'd1, 5'd2, 1'b1, 5'd0, 1'b1, 1'b0);   // add r0
    tick();
    set_id(0, 1'b1, 5'd0, 5'd0, 1'b1, 5'd4, 1'b1, 1'b0);
    #1;
    checks++; if (hazard[0] !== 1'b0) begin errors++; $display("FAIL r0_hazard: got %0d want 0", hazard[0]); end
    tick();
    set_id(0, 1'b1, 5'd1, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1);   // lw r0
    #1;
    checks++; if (fwd_a_sel[0] !== 2'd0) begin errors++; $display("FAIL r0_fwd_a: got %0d want 0", fwd_a_sel[0]); end
    checks++; if (fwd_b_sel[0] !== 2'd0) begin errors++; $display("FAIL r0_fwd_b: got %0d want 0", fwd_b_sel[0]); end
    tick();
    set_id(0, 1'b1, 5'd0, 5'd0, 1'b1, 5'd4, 1'b1, 1'b0);
    #1;
    checks++; if (hazard[0] !== 1'b0) begin errors++; $display("FAIL r0_load_hazard: got %0d want 0", hazard[0]); end
    drain();
  endtask

  task automatic test_flush_hazard();
    is_forward[0] = 1'b1;
    set_id(0, 1'b1, 5'd1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1);   // lw r5
    tick();
    set_id(0, 1'b1, 5'd5, 5'd5, 1'b1, 5'd6, 1'b1, 1'b0);
    flush[0] = 1'b1;
    #1;
    checks++; if (hazard[0] !== 1'b0) begin errors++; $display("FAIL flush_hazard: got %0d want 0", hazard[0]); end
    tick();
    flush[0] = 1'b0;
    set_id(0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    tick();
    #1;
    checks++; if (fwd_a_sel[0] !== 2'd0) begin errors++; $display("FAIL flush_fwd_a: got %0d want 0", fwd_a_sel[0]); end
    checks++; if (fwd_b_sel[0] !== 2'd0) begin errors++; $display("FAIL flush_fwd_b: got %0d want 0", fwd_b_sel[0]); end
    drain();
  endtask

  task automatic test_stall_wb();
    is_forward[0] = 1'b0;
    set_id(0, 1'b1, 5'd1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0);   // add r3
    tick();
    set_id(0, 1'b1, 5'd1, 5'd2, 1'b1, 5'd8, 1'b1, 1'b0);
    tick();
    set_id(0, 1'b1, 5'd1, 5'd2, 1'b1, 5'd9, 1'b1, 1'b0);
    tick();
    set_id(0, 1'b1, 5'd3, 5'd3, 1'b1, 5'd4, 1'b1, 1'b0);   // reader of r3, writer now in WB
    #1;
    checks++; if (hazard[0] !== 1'b0) begin errors++; $display("FAIL wb_dist_hazard: got %0d want 0", hazard[0]); end
    tick();
    set_id(0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    #1;
    checks++; if (fwd_a_sel[0] !== 2'd0) begin errors++; $display("FAIL wb_dist_fwd_a: got %0d want 0", fwd_a_sel[0]); end
    checks++; if (fwd_b_sel[0] !== 2'd0) begin errors++; $display("FAIL wb_dist_fwd_b: got %0d want 0", fwd_b_sel[0]); end
    drain();
  endtask

  task automatic test_mem_wait();
    is_forward[1] = 1'b1;
    set_id(1, 1'b1, 5'd1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1);   // lw r5
    tick();
    set_id(1, 1'b1, 5'd5, 5'd5, 1'b1, 5'd7, 1'b1, 1'b0);   // add r7,r5,r5 held in ID
    #1;
    checks++; if (hazard[1] !== 1'b1) begin errors++; $display("FAIL wait_lu_hazard: got %0d want 1", hazard[1]); end
    checks++; if (mem_busy[1] !== 1'b0) begin errors++; $display("FAIL wait_pre_busy: got %0d want 0", mem_busy[1]); end
    tick();
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++; if (mem_busy[1] !== 1'b1) begin errors++; $display("FAIL wait_busy c%0d: got %0d want 1", c, mem_busy[1]); end
      checks++; if (freeze[1] !== 1'b1) begin errors++; $display("FAIL wait_freeze c%0d: got %0d want 1", c, freeze[1]); end
      tick();
    end
    #1;
    checks++; if (mem_busy[1] !== 1'b0) begin errors++; $display("FAIL wait_end_busy: got %0d want 0", mem_busy[1]); end
    checks++; if (freeze[1] !== 1'b0) begin errors++; $display("FAIL wait_end_freeze: got %0d want 0", freeze[1]); end
    tick();
    set_id(1, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    #1;
    checks++; if (fwd_a_sel[1] !== 2'd2) begin errors++; $display("FAIL wait_fwd_a: got %0d want 2", fwd_a_sel[1]); end
    checks++; if (fwd_b_sel[1] !== 2'd2) begin errors++; $display("FAIL wait_fwd_b: got %0d want 2", fwd_b_sel[1]); end
    drain();
    // Load in MEM waiting, second load in EX, its consumer in ID, flush raised while busy.
    set_id(1, 1'b1, 5'd1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1);
    tick();
    set_id(1, 1'b1, 5'd1, 5'd0, 1'b0, 5'd6, 1'b1, 1'b1);
    tick();
    set_id(1, 1'b1, 5'd6, 5'd6, 1'b1, 5'd7, 1'b1, 1'b0);
    flush[1] = 1'b1;
    #1;
    checks++; if (hazard[1] !== 1'b1) begin errors++; $display("FAIL busy_flush_hazard: got %0d want 1", hazard[1]); end
    checks++; if (freeze[1] !== 1'b1) begin errors++; $display("FAIL busy_flush_freeze: got %0d want 1", freeze[1]); end
    flush[1] = 1'b0;
    drain();
  endtask

  task automatic test_reset_mid_wait();
    is_forward[1] = 1'b1;
    set_id(1, 1'b1, 5'd1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1);
    tick();
    set_id(1, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    tick();
    tick();
    #1;
    checks++; if (mem_busy[1] !== 1'b1) begin errors++; $display("FAIL rstw_busy_before: got %0d want 1", mem_busy[1]); end
    rst = 1'b1;
    #1;
    checks++; if (mem_busy[1] !== 1'b0) begin errors++; $display("FAIL rstw_busy_async: got %0d want 0", mem_busy[1]); end
    checks++; if (freeze[1] !== 1'b0) begin errors++; $display("FAIL rstw_freeze_async: got %0d want 0", freeze[1]); end
    @(negedge clk);
    rst = 1'b0;
    tick();
    #1;
    checks++; if (mem_busy[1] !== 1'b0) begin errors++; $display("FAIL rstw_busy_after: got %0d want 0", mem_busy[1]); end
    drain();
  endtask

  task automatic test_random(input int k, input int wait_cycles);
    instr_t   nw;
    bit       exp_haz, exp_busy, moving_load;
    bit [1:0] exp_a, exp_b;
    rst = 1'b1;
    #2;
    rst = 1'b0;
    for (int s = 0; s < 3; s++) m_pipe[s] = '{default: 0};
    m_wait_left = 0;
    for (int n = 0; n < 400; n++) begin
      is_forward[k] = (n < 200);
      set_id(k, ($urandom_range(0, 3) != 0), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
             1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), 1'($urandom_range(0, 3) != 0),
             1'($urandom_range(0, 2) == 0));
      flush[k] = ($urandom_range(0, 7) == 0);
      #1;
      exp_busy = (m_wait_left != 0);
      exp_haz  = model_hazard(k);
      exp_a    = model_sel(k, m_pipe[0].s1, 1'b1);
      exp_b    = model_sel(k, m_pipe[0].s2, m_pipe[0].u);
      checks++; if (hazard[k] !== exp_haz) begin errors++; $display("FAIL rnd%0d_hazard n%0d: got %0d want %0d", k, n, hazard[k], exp_haz); end
      checks++; if (mem_busy[k] !== exp_busy) begin errors++; $display("FAIL rnd%0d_busy n%0d: got %0d want %0d", k, n, mem_busy[k], exp_busy); end
      checks++; if (freeze[k] !== (exp_haz | exp_busy)) begin errors++; $display("FAIL rnd%0d_freeze n%0d: got %0d want %0d", k, n, freeze[k], exp_haz | exp_busy); end
      checks++; if (fwd_a_sel[k] !== exp_a) begin errors++; $display("FAIL rnd%0d_fwd_a n%0d: got %0d want %0d", k, n, fwd_a_sel[k], exp_a); end
      checks++; if (fwd_b_sel[k] !== exp_b) begin errors++; $display("FAIL rnd%0d_fwd_b n%0d: got %0d want %0d", k, n, fwd_b_sel[k], exp_b); end
      if (exp_busy) begin
        m_wait_left--;
      end else begin
        moving_load = m_pipe[0].v && m_pipe[0].mr;
        nw = '{v: 1'b1, d: id_dest[k], wb: id_wb_en[k], mr: id_mem_r_en[k],
               s1: id_src1[k], s2: id_src2[k], u: id_src2_used[k]};
        m_pipe[2] = m_pipe[1];
        m_pipe[1] = m_pipe[0];
        if (id_valid[k] && !exp_haz && !flush[k]) m_pipe[0] = nw;
        else m_pipe[0] = '{default: 0};
        m_wait_left = moving_load ? wait_cycles : 0;
      end
      tick();
    end
    drain();
  endtask

  initial begin
    rst = 1'b1;
    is_forward = 2'b00; flush = 2'b00;
    for (int k = 0; k < 2; k++) set_id(k, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    test_reset();
    test_forward();
    test_load_use();
    test_reg_zero();
    test_flush_hazard();
    test_stall_wb();
    test_mem_wait();
    test_reset_mid_wait();
    test_random(0, 0);
    test_random(1, 3);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hazard_fwd_scoreboard.md
# hazard_fwd_scoreboard

Parametrised hazard-detection and forwarding controller for the 5-stage MIPS pipeline, replacing the separate stateless hazard and forwarding units. It keeps its own shadow copies of the EXE, MEM and WB stage control fields, derives operand-forward selects for the instruction in EXE, and generates the ID stall. Unlike the current design, it supports a multi-cycle data memory: loads hold MEM for `MEM_WAIT` extra cycles while the whole pipeline freezes.

## Interface
- `REG_AW`, 5, register address width; register 0 is hardwired zero.
- `MEM_WAIT`, 0, extra cycles a load occupies MEM (0 = single-cycle memory).

- `clk`  in  1  pipeline clock
- `rst`  in  1  reset, asynchronous, active-high
- `is_forward`  in  1  1 = forwarding mode, 0 = stall-only mode
- `id_valid`  in  1  ID holds a real instruction
- `id_src1`, `id_src2`  in  REG_AW  ID source registers
- `id_src2_used`  in  1  instruction reads src2 (R-type, store, branch)
- `id_dest`  in  REG_AW  ID destination
- `id_wb_en`, `id_mem_r_en`  in  1  ID control
- `flush`  in  1  branch taken in EXE; ID instruction is discarded
- `hazard`  out  1  ID must stall (IF/ID hold, bubble into EXE)
- `freeze`  out  1  all pipeline registers hold (`hazard | mem_busy`)
- `mem_busy`  out  1  load waiting in MEM
- `fwd_a_sel`, `fwd_b_sel`  out  2  EXE operand select: 0 regfile, 1 MEM ALU result, 2 WB value

## Operation
- Shadow entries EX, MEM, WB: `valid`, `dest`, `wb_en`, `mem_r`; EX also holds `src1`, `src2`, `src2_used`.
- Advance cycle (`!mem_busy`):
  - WB←MEM, MEM←EX.
  - EX←ID fields if `id_valid & !hazard & !flush`; otherwise EX←bubble (valid=0).
- Busy cycle (`mem_busy`): all entries and `flush` are ignored and held.
- Wait counter, width clog2(MEM_WAIT+1):
  - Loaded with MEM_WAIT on the advancing edge that moves a valid load into MEM.
  - Decrements while nonzero.
  - `mem_busy = (cnt != 0)`.
  - With MEM_WAIT=0 the counter is absent and `mem_busy`=0.
- A "match" requires `valid & wb_en & dest != 0 & dest == src`; src2 only counts when `src2_used`.
- Hazard, forwarding mode: `id_valid` and the EX entry is a load (`mem_r`) matching `id_src1`/`id_src2`.
- Hazard, stall-only mode: `id_valid` and EX or MEM matches. A WB match is not a hazard because the register file writes before it reads.
- `hazard` is forced to 0 while `flush` is asserted, since the ID instruction is being discarded.
- Forward selects, forwarding mode: MEM match → 1; else WB match → 2; else 0. MEM wins when both match. Sources are the EX entry's src1/src2.
- Forward selects, stall-only mode: always 0.
- Selects are 0 when the EX entry is invalid.
- A load in MEM never forwards (its `mem_r` is set). The hazard rule guarantees this case does not arise in forwarding mode.

## Timing
- `hazard`, `freeze` and `fwd_*_sel` are combinational from the ID inputs and the shadow registers, with no added latency.
- Shadow state updates on posedge `clk`.
- Load-use in forwarding mode costs 1 bubble.
- Each load costs MEM_WAIT freeze cycles.
- Reset (asynchronous, any time, including mid-wait) drives:
  - all valids = 0 and counter = 0
  - `hazard`, `freeze`, `mem_busy` = 0
  - selects = 0
- Simultaneous `flush` and hazard condition: flush wins, EX gets a bubble, `hazard`=0.
- `flush` during `mem_busy` is ignored. The branch remains in EX and is re-asserted by EXE on the advancing cycle.
- `is_forward` is quasi-static; changes take effect combinationally.

## Structure
- Shared `mips_pipe_pkg` holds:
  - constants `FWD_REG`=0, `FWD_MEM`=1, `FWD_WB`=2
  - struct `stage_ctl_t` {valid, dest, wb_en, mem_r}
  - the stage-entry bubble constant
- One sub-module, `reg_match`: a combinational comparator, instantiated per (stage, source) pair.
- Counter and shadow registers live in the top.

## Test plan
- Forwarding: `add r3` then `sub r4,r3,r3` back-to-back → next cycle `fwd_a_sel`=`fwd_b_sel`=1, `hazard`=0. With one independent instruction between them → selects=2.
- Load-use: `lw r5` then `add r6,r5,r0` with `is_forward`=1 → `hazard`=1 for 1 cycle, then `fwd_a_sel`=2 with `fwd_b_sel`=0. With `is_forward`=0 → `hazard`=1 for 2 cycles, selects 0.
- Register zero: `add r0` followed by a reader of r0 → `hazard`=0, selects=0.
- MEM_WAIT=3: `lw` enters MEM → `mem_busy`/`freeze`=1 for exactly 3 cycles, shadows unchanged throughout, then advance. Assert `rst` during the 2nd wait cycle → `mem_busy`=0 immediately and the counter clears.
- Flush with hazard: `flush`=1 in the same cycle as a load-use match → `hazard`=0, EX entry invalid next cycle, selects 0.
- Stall-only mode, WB distance: writer three instructions ahead → `hazard`=0, selects 0.
